// File: rtl/hub75_capture_if.sv
// hub75_capture_if
//   Bundles the HUB75 screen wires driven by the GPU and the framebuffer
//   write port rebuilt from them.
//   master : the GPU/bench side; drives hub_*, observes fb_*.
//   slave  : the capture block; samples hub_*, drives fb_*.
//   hub_RGB0/1  {R,G,B} for the top / bottom panel half
//   hub_CLK     screen shift clock
//   hub_ABCDE   row select
//   hub_LATCH   line latch
//   hub_nOE     active-low output enable
//   fb_we       framebuffer write strobe
//   fb_addr     {half, row, col}, half 0 = top
//   fb_wdata    pixel {R,G,B}
interface hub75_capture_if #(
  parameter int ROW_BITS = 5,
  parameter int COL_BITS = 6
);
  logic [2:0]                   hub_RGB0;
  logic [2:0]                   hub_RGB1;
  logic                         hub_CLK;
  logic [ROW_BITS-1:0]          hub_ABCDE;
  logic                         hub_LATCH;
  logic                         hub_nOE;
  logic                         fb_we;
  logic [ROW_BITS+COL_BITS:0]   fb_addr;
  logic [2:0]                   fb_wdata;

  modport master (
    output hub_RGB0, hub_RGB1, hub_CLK, hub_ABCDE, hub_LATCH, hub_nOE,
    input  fb_we, fb_addr, fb_wdata
  );

  modport slave (
    input  hub_RGB0, hub_RGB1, hub_CLK, hub_ABCDE, hub_LATCH, hub_nOE,
    output fb_we, fb_addr, fb_wdata
  );
endinterface

// File: rtl/hub75_capture.sv
// hub75_capture
//   Panel model sitting on the GPU's HUB75 wires. Shifts RGB0/RGB1 into one
//   line per panel half on each screen-clock rise and, on LATCH, replays the
//   line into a framebuffer write port addressed by the ABCDE row:
//   COLS top-half writes followed by COLS bottom-half writes.
//   clk          system clock (same clock as the GPU)
//   rst          synchronous active-high reset
//   bus          hub75_capture_if.slave: hub_* inputs, fb_* write port
//   line_done    one-cycle pulse after the last write of a line
//   frame_done   pulse alongside line_done when the row was all-ones
//   shift_count  shift-clock rises since the previous latch, saturating
//   oe_active    registered ~hub_nOE (informational only)
//   overrun_err  sticky: a latch arrived while a line was being written
module hub75_capture #(
  parameter int COLS     = 64,
  parameter int ROW_BITS = 5,
  parameter int COL_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  hub75_capture_if.slave      bus,
  output logic                line_done,
  output logic                frame_done,
  output logic [COL_BITS:0]   shift_count,
  output logic                oe_active,
  output logic                overrun_err
);

  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
  localparam logic [COL_BITS:0]   FULL_CNT = (COL_BITS + 1)'(COLS);

  typedef enum logic [1:0] {IDLE, WR_TOP, WR_BOT} state_t;

  // Input synchronisers
  logic [2:0]          rgb0_s1, rgb1_s1;
  logic [ROW_BITS-1:0] row_s1;
  logic                clk_s1, clk_s2;
  logic                latch_s1, latch_s2;
  logic                arm_pre, arm;

  logic                clk_rise, latch_rise;

  // Shift registers (element 0 = newest pixel) and their next values
  logic [COLS-1:0][2:0] top_sr, bot_sr;
  logic [COLS-1:0][2:0] top_nxt, bot_nxt;

  // Write buffer captured at latch time
  logic [COLS-1:0][2:0] top_buf, bot_buf;
  logic [ROW_BITS-1:0]  row_buf;

  state_t              state;
  logic [COL_BITS-1:0] col;
  logic [COL_BITS-1:0] col_inc;

  // NOTE: every signal assigned here gets a value on every path, so no
  // latches are inferred.
  always_comb begin
    clk_rise   = arm & clk_s1 & ~clk_s2;
    latch_rise = arm & latch_s1 & ~latch_s2;
    top_nxt    = top_sr;
    bot_nxt    = bot_sr;
    if (clk_rise) begin
      top_nxt = {top_sr[COLS-2:0], rgb0_s1};
      bot_nxt = {bot_sr[COLS-2:0], rgb1_s1};
    end
    col_inc = col + 1'b1;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others.
  // The arm bit comes up two edges after reset so that inputs already high
  // at release (s1 = 1, s2 = 0 for one cycle) are not taken as edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb0_s1   <= '0;
      rgb1_s1   <= '0;
      row_s1    <= '0;
      clk_s1    <= 1'b0;
      clk_s2    <= 1'b0;
      latch_s1  <= 1'b0;
      latch_s2  <= 1'b0;
      arm_pre   <= 1'b0;
      arm       <= 1'b0;
      oe_active <= 1'b0;
    end else begin
      rgb0_s1   <= bus.hub_RGB0;
      rgb1_s1   <= bus.hub_RGB1;
      row_s1    <= bus.hub_ABCDE;
      clk_s1    <= bus.hub_CLK;
      clk_s2    <= clk_s1;
      latch_s1  <= bus.hub_LATCH;
      latch_s2  <= latch_s1;
      arm_pre   <= 1'b1;
      arm       <= arm_pre;
      oe_active <= ~bus.hub_nOE;
    end
  end

  // Shift registers and shift counter. A latch restarts the count; a
  // shift in the same cycle is the first pixel of the new line.
  // NOTE: the shift registers and write buffer are reset explicitly so a
  // short line after reset writes zeros in its unshifted columns.
  always_ff @(posedge clk) begin
    if (rst) begin
      top_sr      <= '0;
      bot_sr      <= '0;
      shift_count <= '0;
    end else begin
      top_sr <= top_nxt;
      bot_sr <= bot_nxt;
      if (latch_rise)
        shift_count <= clk_rise ? (COL_BITS + 1)'(1) : '0;
      else if (clk_rise && shift_count != FULL_CNT)
        shift_count <= shift_count + 1'b1;
    end
  end

  // Write sequencer. state/col name the write currently on the bus; the
  // fb_* outputs are registered alongside them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      col          <= '0;
      top_buf      <= '0;
      bot_buf      <= '0;
      row_buf      <= '0;
      bus.fb_we    <= 1'b0;
      bus.fb_addr  <= '0;
      bus.fb_wdata <= '0;
      line_done    <= 1'b0;
      frame_done   <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (latch_rise) begin
            top_buf      <= top_nxt;
            bot_buf      <= bot_nxt;
            row_buf      <= row_s1;
            col          <= '0;
            state        <= WR_TOP;
            bus.fb_we    <= 1'b1;
            bus.fb_addr  <= {1'b0, row_s1, {COL_BITS{1'b0}}};
            bus.fb_wdata <= top_nxt[0];
          end
        end
        WR_TOP: begin
          if (col == LAST_COL) begin
            col          <= '0;
            state        <= WR_BOT;
            bus.fb_addr  <= {1'b1, row_buf, {COL_BITS{1'b0}}};
            bus.fb_wdata <= bot_buf[0];
          end else begin
            col          <= col_inc;
            bus.fb_addr  <= {1'b0, row_buf, col_inc};
            bus.fb_wdata <= top_buf[col_inc];
          end
        end
        WR_BOT: begin
          if (col == LAST_COL) begin
            col          <= '0;
            state        <= IDLE;
            bus.fb_we    <= 1'b0;
            bus.fb_addr  <= '0;
            bus.fb_wdata <= '0;
            line_done    <= 1'b1;
            frame_done   <= &row_buf;
          end else begin
            col          <= col_inc;
            bus.fb_addr  <= {1'b1, row_buf, col_inc};
            bus.fb_wdata <= bot_buf[col_inc];
          end
        end
        default: state <= IDLE;
      endcase
      // A latch during a write sequence leaves the buffer alone.
      if (latch_rise && state != IDLE)
        overrun_err <= 1'b1;
    end
  end

endmodule
